// File: rtl/mult_operand_feeder.sv
// Operand FIFO and issue sequencer feeding sequential_multiplier.
// Define FEEDER_TIMEOUT_EN to add the WAIT-state timeout and sticky err.
module mult_operand_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic [3:0]                 m,
  output logic [3:0]                 q,
  output logic                       start,
  input  logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [7:0]                 issued_cnt,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          tmo;

  assign in_ready = (cnt != LW'(DEPTH)) & ~reset;
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) & (cnt != '0);
  assign level    = cnt;
  assign start    = (state == ISSUE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (pop) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (done || tmo) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m <= '0;
      q <= '0;
    end else if (pop) begin
      q <= mem[rd_ptr][7:4];
      m <= mem[rd_ptr][3:0];
    end
  end

  // done wins over a simultaneous timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt <= '0;
    end else if ((state == WAIT) && done) begin
      issued_cnt <= issued_cnt + 8'd1;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] tcnt;

  assign tmo = (state == WAIT) & ~done & (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tcnt <= '0;
      end else if ((state == WAIT) && !done) begin
        tcnt <= tcnt + TW'(1);
      end
      if (tmo) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Directed bench for mult_operand_feeder with issue-order scoreboard.
module tb_mult_operand_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [3:0]    m;
  logic [3:0]    q;
  logic          start;
  logic          done;
  logic          busy;
  logic [LW-1:0] level;
  logic [7:0]    issued_cnt;
  logic          err;

  mult_operand_feeder #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .m          (m),
    .q          (q),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .level      (level),
    .issued_cnt (issued_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int         nerr = 0;
  int         nchk = 0;
  logic [7:0] sb[$];
  int         start_cnt = 0;
  int         cyc = 0;
  int         last_start = -100;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // each start pulse must carry the oldest accepted pair
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (start === 1'b1) begin
      start_cnt++;
      chk("start_gap", 32'(cyc - last_start >= 3), 32'd1);
      last_start = cyc;
      chk("issue_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("issue_m", 32'(m), 32'(e[3:0]));
        chk("issue_q", 32'(q), 32'(e[7:4]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input int tries,
                      output bit acc);
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < tries; i++) begin
      if (in_ready === 1'b1) acc = 1'b1;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(d);
  endtask

  task automatic wait_start(input int max);
    for (int i = 0; i < max; i++) begin
      if (start === 1'b1) break;
      tick();
    end
    chk("start_seen", 32'(start), 32'd1);
  endtask

  task automatic to_wait(input int max);
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b1 && start === 1'b0) break;
      tick();
    end
    chk("reach_wait", 32'(busy === 1'b1 && start === 1'b0), 32'd1);
  endtask

  task automatic give_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic serve(input int k);
    to_wait(30);
    repeat (k - 1) tick();
    give_done();
  endtask

  initial begin
    bit acc;
    int sc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    done = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_mq", 32'({m, q}), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_level", 32'(level), 32'd0);

    push(8'hBD, 1, acc);
    chk("single_acc", 32'(acc), 32'd1);
    chk("single_level1", 32'(level), 32'd1);
    wait_start(5);
    chk("single_m", 32'(m), 32'hD);
    chk("single_q", 32'(q), 32'hB);
    chk("single_level0", 32'(level), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    serve(4);
    chk("single_issued", 32'(issued_cnt), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_starts", 32'(start_cnt), 32'd1);

    push(8'hBD, 1, acc);
    chk("b2b_acc0", 32'(acc), 32'd1);
    push(8'h38, 1, acc);
    chk("b2b_acc1", 32'(acc), 32'd1);
    serve(1);
    serve(1);
    chk("b2b_issued", 32'(issued_cnt), 32'd3);
    chk("b2b_starts", 32'(start_cnt), 32'd3);
    chk("b2b_mq", 32'({m, q}), 32'h83);

    for (int i = 1; i <= 5; i++) begin
      push(8'(i * 8'h11), 1, acc);
      chk("full_acc", 32'(acc), 32'd1);
    end
    chk("full_level", 32'(level), 32'd4);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    push(8'h66, 1, acc);
    chk("full_held_off", 32'(acc), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    give_done();
    push(8'h66, 10, acc);
    chk("full_late_acc", 32'(acc), 32'd1);
    repeat (5) serve(1);
    chk("wrap_issued", 32'(issued_cnt), 32'd9);
    chk("wrap_starts", 32'(start_cnt), 32'd9);
    chk("wrap_level", 32'(level), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    push(8'hA1, 1, acc);
    push(8'hB2, 1, acc);
    push(8'hC3, 1, acc);
    chk("mid_level2", 32'(level), 32'd2);
    chk("mid_in_wait", 32'(busy === 1'b1 && start === 1'b0), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_issued", 32'(issued_cnt), 32'd0);
    chk("mid_mq", 32'({m, q}), 32'd0);
    reset = 1'b0;
    sb.delete();
    sc = start_cnt;
    repeat (8) tick();
    chk("mid_no_start", 32'(start_cnt), 32'(sc));
    chk("mid_level_after", 32'(level), 32'd0);

    push(8'h5A, 1, acc);
    push(8'hC7, 1, acc);
    to_wait(10);
`ifdef FEEDER_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    chk("tmo_err_pre", 32'(err), 32'd0);
    chk("tmo_busy_pre", 32'(busy), 32'd1);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_issued", 32'(issued_cnt), 32'd0);
    serve(1);
    chk("tmo_next_issued", 32'(issued_cnt), 32'd1);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_next_mq", 32'({m, q}), 32'h7C);
`else
    repeat (TIMEOUT + 4) tick();
    chk("notmo_err", 32'(err), 32'd0);
    chk("notmo_busy", 32'(busy), 32'd1);
    give_done();
    serve(1);
    chk("notmo_issued", 32'(issued_cnt), 32'd2);
    chk("notmo_mq", 32'({m, q}), 32'h7C);
`endif
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
